pulse_period_meter: RTL



---
 rtl/pulse_period_meter_pkg.sv | 18 +
 rtl/pulse_period_meter_sync_edge.sv | 63 ++++++
 rtl/pulse_period_meter.sv | 116 +++++++++++
 3 files changed

// File: rtl/pulse_period_meter_pkg.sv
// Shared constants, FSM state type and period helper for pulse_period_meter.
package pulse_period_meter_pkg;

  localparam int CPU_CLOCK = 27_000_000;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRST   = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

  // Expected meas_period, in clk cycles, for a square wave of the given frequency.
  function automatic int clocks_per_period(input int hz);
    return CPU_CLOCK / hz;
  endfunction

endpackage

// File: rtl/pulse_period_meter_sync_edge.sv
// pulse_sync_edge: 2-FF synchroniser and registered rise/fall strobes for slow inputs.
// Define PULSE_METER_FILTER_EN to insert a FILTER_LEN-sample glitch filter after the synchroniser.
module pulse_sync_edge #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_d;

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 1");
  end

`ifdef PULSE_METER_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] stable_cnt;
  logic          filt;

  // The level flips only after FILTER_LEN consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      filt       <= 1'b0;
    end else if (sync2 == filt) begin
      stable_cnt <= '0;
    end else if (stable_cnt == FW'(FILTER_LEN - 1)) begin
      stable_cnt <= '0;
      filt       <= sync2;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_d <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync1   <= pulse_in;
      sync2   <= sync1;
      level_d <= level;
      rise    <= level & ~level_d;
      fall    <= ~level & level_d;
    end
  end

endmodule

// File: rtl/pulse_period_meter.sv
// Measures period and high time of a slow asynchronous pulse in clk cycles, with loss detection.
// Build option PULSE_METER_FILTER_EN enables the input glitch filter in pulse_sync_edge.
//
// Handshake: a measurement is transferred on any clk edge where meas_valid && meas_ready;
// meas_period/meas_high are stable while meas_valid is high and not yet accepted.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = CPU_CLOCK,
  parameter int FILTER_LEN     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             signal_lost,
  output logic             overrun,
  input  logic             clr_overrun,
  output meter_state_t     dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_lat;
  meter_state_t     state;
  logic             capture;
  logic             accept;
  logic             timeout;

  pulse_sync_edge #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .rise     (rise),
    .fall     (fall)
  );

  assign capture   = rise && (state != IDLE);
  assign accept    = meas_valid && meas_ready;
  assign timeout   = !rise && (cnt == TIMEOUT);
  assign dbg_state = state;

  // Counts cycles since the last rise strobe; saturates so a dead input never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      high_lat    <= '0;
      signal_lost <= 1'b1;
      meas_period <= '0;
      meas_high   <= '0;
      meas_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state       <= FIRST;
            signal_lost <= 1'b0;
            high_lat    <= '0;
          end
        end
        FIRST, MEASURE: begin
          if (rise) begin
            state    <= MEASURE;
            high_lat <= '0;
          end else if (timeout) begin
            state       <= IDLE;
            signal_lost <= 1'b1;
            high_lat    <= '0;
          end else if (fall) begin
            high_lat <= cnt;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // A capture may replace data in the very cycle the old data is accepted.
      if (capture && (!meas_valid || meas_ready)) begin
        meas_period <= cnt;
        meas_high   <= high_lat;
        meas_valid  <= 1'b1;
      end else if (accept) begin
        meas_valid <= 1'b0;
      end

      if (capture && meas_valid && !meas_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
